// File: rtl/matmul_drain_pkg.sv
// Shared definitions for the output-matrix drain: FSM states and the buffer address map.
// ROWS/COLS fall back to 4x4 when the build does not define them.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

package matmul_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PRESENT,
    DONE
  } drain_state_e;

  // Row-major word layout; the output collector uses the same mapping.
  function automatic int unsigned buf_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/matmul_output_drain_if.sv
// Drain-side bus: control, output-buffer read/clear port and the row stream.
interface matmul_output_drain_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ROWS       = `ROWS,
  parameter int COLS       = `COLS,
  parameter int ADDR_WIDTH = $clog2(ROWS*COLS),
  parameter int ROW_WIDTH  = $clog2(ROWS)+1
);

  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [WORD_SIZE-1:0]      rd_data;
  logic                      clr_we;
  logic [ADDR_WIDTH-1:0]     clr_addr;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*WORD_SIZE-1:0] out_data;
  logic [ROW_WIDTH-1:0]      out_row;
  logic                      out_last;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_en, rd_addr, clr_we, clr_addr,
           out_valid, out_data, out_row, out_last
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr, clr_we, clr_addr,
           out_valid, out_data, out_row, out_last
  );

endinterface

// File: rtl/matmul_output_drain.sv
// Streams the accumulated ROWSxCOLS output buffer out one row per valid/ready beat.
// Define CLEAR_ON_READ_EN to zero each word as it is read (buffer ready for the next pass).
module matmul_output_drain
  import matmul_drain_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int ROWS       = `ROWS,
  parameter int COLS       = `COLS,
  parameter int ADDR_WIDTH = $clog2(ROWS*COLS)
) (
  input logic                   clk,
  input logic                   rst,
  matmul_output_drain_if.master bus
);

  localparam int ROW_W = $clog2(ROWS) + 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  drain_state_e state_q, state_d;

  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic                  rd_vld_q;
  logic [COL_W-1:0]      cap_col_q;
  logic [WORD_SIZE-1:0]  lane_q [COLS];
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic                  last_row;
  logic                  last_col;

  assign last_row  = (row_q == ROW_W'(ROWS-1));
  assign last_col  = (col_q == COL_W'(COLS-1));
  assign rd_addr_c = ADDR_WIDTH'(buf_addr(32'(row_q), 32'(col_q), unsigned'(COLS)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)     state_d = FETCH;
      FETCH:   if (last_col)      state_d = WAIT;
      WAIT:                       state_d = PRESENT;
      PRESENT: if (bus.out_ready) state_d = last_row ? DONE : FETCH;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.rd_en     = (state_q == FETCH);
    bus.out_valid = (state_q == PRESENT);
    bus.out_last  = (state_q == PRESENT) && last_row;
  end

  // Read data lands one cycle after its strobe, so the lane index travels with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      rd_vld_q  <= 1'b0;
      cap_col_q <= '0;
      for (int c = 0; c < COLS; c++) lane_q[c] <= '0;
    end else begin
      rd_vld_q  <= bus.rd_en;
      cap_col_q <= col_q;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            row_q <= '0;
            col_q <= '0;
          end
        end
        FETCH:   col_q <= last_col ? '0 : col_q + COL_W'(1);
        PRESENT: if (bus.out_ready && !last_row) row_q <= row_q + ROW_W'(1);
        default: ;
      endcase
      if (rd_vld_q) lane_q[cap_col_q] <= bus.rd_data;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < COLS; c++) bus.out_data[c*WORD_SIZE +: WORD_SIZE] = lane_q[c];
  end

  assign bus.out_row = row_q;
  assign bus.rd_addr = rd_addr_c;

`ifdef CLEAR_ON_READ_EN
  logic [ADDR_WIDTH-1:0] cap_addr_q;

  // The zero-write trails the read by one cycle, never touching a word still being fetched.
  always_ff @(posedge clk) begin
    if (rst) cap_addr_q <= '0;
    else     cap_addr_q <= rd_addr_c;
  end

  assign bus.clr_we   = rd_vld_q;
  assign bus.clr_addr = cap_addr_q;
`else
  assign bus.clr_we   = 1'b0;
  assign bus.clr_addr = '0;
`endif

endmodule
